// File: rtl/mem_stage_if.sv
// Data-cache request bus between mem_stage and the D-cache.
// Master side issues requests; slave side answers with data/busy.
interface mem_stage_if #(
  parameter int BIT_W = 32
);
  logic             dc_req_o;
  logic             dc_wen_o;
  logic [BIT_W-3:0] dc_addr_o;
  logic [BIT_W-1:0] dc_wdata_o;
  logic [BIT_W-1:0] dc_rdata_i;
  logic             dc_busy_i;

  modport master (
    output dc_req_o,
    output dc_wen_o,
    output dc_addr_o,
    output dc_wdata_o,
    input  dc_rdata_i,
    input  dc_busy_i
  );

  modport slave (
    input  dc_req_o,
    input  dc_wen_o,
    input  dc_addr_o,
    input  dc_wdata_o,
    output dc_rdata_i,
    output dc_busy_i
  );
endinterface

// File: rtl/mem_stage.sv
// RV32 memory-access stage: D-cache request FSM, freeze
// generation, load-data buffering and the MEM/WB register.
module mem_stage #(
  parameter int BIT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIT_W-1:0] alu_result_i,
  input  logic [BIT_W-1:0] mem_wdata_i,
  input  logic [4:0]       rd_i,
  input  logic [BIT_W-1:0] pc_step_i,
  input  logic             memrd_i,
  input  logic             memwr_i,
  input  logic             mem2reg_i,
  input  logic             regwr_i,
  input  logic             jump_i,
  input  logic             mul_ppl_i,
  input  logic [BIT_W-1:0] mul_result_i,
  input  logic             stall_ext_i,
  mem_stage_if.master      dc,
  output logic             stall_o,
  output logic [BIT_W-1:0] wb_data_o,
  output logic [4:0]       wb_rd_o,
  output logic             wb_regwr_o,
  output logic             misalign_o,
  output logic [15:0]      stall_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [BIT_W-1:0] rbuf_q, rbuf_d;
  logic [BIT_W-1:0] wb_data_q, wb_data_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic             wb_regwr_q, wb_regwr_d;
  logic             misalign_q, misalign_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;

  logic             mem_op;
  logic             req;
  logic             stall;
  logic [BIT_W-1:0] ld_data;
  logic [BIT_W-1:0] wb_sel;

  assign mem_op = memrd_i | memwr_i;

  // Request FSM: issue, wait out cache busy, park data
  // in rbuf while the rest of the pipe is frozen.
  always_comb begin
    state_d = state_q;
    rbuf_d  = rbuf_q;
    req     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req = mem_op;
        if (mem_op && dc.dc_busy_i) begin
          state_d = S_WAIT;
        end else if (mem_op && stall_ext_i) begin
          state_d = S_HOLD;
          rbuf_d  = dc.dc_rdata_i;
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (!dc.dc_busy_i) begin
          if (stall_ext_i) begin
            state_d = S_HOLD;
            rbuf_d  = dc.dc_rdata_i;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (!stall_ext_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Freeze, writeback select, MEM/WB, sticky flag, counter.
  always_comb begin
    stall   = stall_ext_i | (req & dc.dc_busy_i);
    ld_data = (state_q == S_HOLD) ? rbuf_q : dc.dc_rdata_i;
    if (mem2reg_i)      wb_sel = ld_data;
    else if (jump_i)    wb_sel = pc_step_i;
    else if (mul_ppl_i) wb_sel = mul_result_i;
    else                wb_sel = alu_result_i;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_regwr_d = 1'b0;
    if (!stall) begin
      wb_data_d  = wb_sel;
      wb_rd_d    = rd_i;
      wb_regwr_d = regwr_i;
    end
    misalign_d = misalign_q
               | (mem_op & (|alu_result_i[1:0]));
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State and MEM/WB registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rbuf_q      <= '0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_regwr_q  <= 1'b0;
      misalign_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rbuf_q      <= rbuf_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      wb_regwr_q  <= wb_regwr_d;
      misalign_q  <= misalign_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dc.dc_req_o   = req;
  assign dc.dc_wen_o   = memwr_i;
  assign dc.dc_addr_o  = alu_result_i[BIT_W-1:2];
  assign dc.dc_wdata_o = mem_wdata_i;
  assign stall_o       = stall;
  assign wb_data_o     = wb_data_q;
  assign wb_rd_o       = wb_rd_q;
  assign wb_regwr_o    = wb_regwr_q;
  assign misalign_o    = misalign_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table plus
// hand sequences, writebacks checked through a scoreboard.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu, wd, pcs, mulr;
  logic [4:0]  rd;
  logic        memrd, memwr, m2r, regwr, jump, mulp, sext;
  logic        stall;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_regwr, mis;
  logic [15:0] scnt;

  mem_stage_if #(.BIT_W(32)) dc();

  mem_stage #(.BIT_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_result_i (alu),
    .mem_wdata_i  (wd),
    .rd_i         (rd),
    .pc_step_i    (pcs),
    .memrd_i      (memrd),
    .memwr_i      (memwr),
    .mem2reg_i    (m2r),
    .regwr_i      (regwr),
    .jump_i       (jump),
    .mul_ppl_i    (mulp),
    .mul_result_i (mulr),
    .stall_ext_i  (sext),
    .dc           (dc),
    .stall_o      (stall),
    .wb_data_o    (wb_data),
    .wb_rd_o      (wb_rd),
    .wb_regwr_o   (wb_regwr),
    .misalign_o   (mis),
    .stall_cnt_o  (scnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } wb_t;

  typedef struct {
    logic [31:0] alu, wd, pcs, mul, rdata;
    logic [4:0]  rd;
    logic        memrd, memwr, m2r, regwr, jump, mulp;
    logic        sext, busy;
    logic        e_req, e_stall, e_regwr;
    logic [31:0] e_data;
    logic [4:0]  e_rd;
  } vec_t;

  wb_t  sbq[$];
  wb_t  mon_e;
  vec_t vq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   nst;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(
    input logic [31:0] a, input logic [31:0] w,
    input logic [4:0] r, input logic [31:0] p,
    input logic [31:0] m, input logic mr, input logic mw,
    input logic mg, input logic rw, input logic j,
    input logic mp, input logic se, input logic b,
    input logic [31:0] rdat);
    alu = a; wd = w; rd = r; pcs = p; mulr = m;
    memrd = mr; memwr = mw; m2r = mg; regwr = rw;
    jump = j; mulp = mp; sext = se;
    dc.dc_busy_i = b; dc.dc_rdata_i = rdat;
  endtask

  task automatic nop;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] r);
    wb_t e;
    e.data = d;
    e.rd = r;
    sbq.push_back(e);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    nop();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic bus_chk(input string nm, input logic er,
                         input logic es);
    @(negedge clk);
    chk({nm, "_req"}, {31'b0, dc.dc_req_o}, {31'b0, er});
    chk({nm, "_stall"}, {31'b0, stall}, {31'b0, es});
    if (stall) nst++;
  endtask

  task automatic add_vec(
    input logic [31:0] a, input logic [31:0] w,
    input logic [4:0] r, input logic [31:0] p,
    input logic [31:0] m, input logic mr, input logic mw,
    input logic mg, input logic rw, input logic j,
    input logic mp, input logic se, input logic b,
    input logic [31:0] rdat, input logic er, input logic es,
    input logic [31:0] ed, input logic [4:0] erd,
    input logic erw);
    vec_t v;
    v.alu = a; v.wd = w; v.rd = r; v.pcs = p; v.mul = m;
    v.memrd = mr; v.memwr = mw; v.m2r = mg; v.regwr = rw;
    v.jump = j; v.mulp = mp; v.sext = se; v.busy = b;
    v.rdata = rdat; v.e_req = er; v.e_stall = es;
    v.e_data = ed; v.e_rd = erd; v.e_regwr = erw;
    vq.push_back(v);
  endtask

  // Scoreboard: every registered writeback must match the
  // oldest expected entry; unexpected writebacks fail.
  always @(posedge clk) begin
    #2;
    if (wb_regwr === 1'b1) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wb_unexpected: got data %h rd %0d, required none",
                 wb_data, wb_rd);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_wb_data", wb_data, mon_e.data);
        chk("sb_wb_rd", {27'b0, wb_rd}, {27'b0, mon_e.rd});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "timeout");
  end

  initial begin
    nop();
    // alu wd rd pcs mul | mr mw mg rw j mp se b rdata | req stall data rd regwr
    add_vec(32'h11112222, 0, 3, 0, 0, 0,0,0,1,0,0, 0,0, 0,
            0, 0, 32'h11112222, 3, 1);
    add_vec(32'h100, 0, 5, 0, 0, 1,0,1,1,0,0, 0,0, 32'hDEADBEEF,
            1, 0, 32'hDEADBEEF, 5, 1);
    add_vec(32'h500, 0, 1, 32'h88, 0, 0,0,0,1,1,0, 0,0, 0,
            0, 0, 32'h88, 1, 1);
    add_vec(32'h7, 0, 9, 0, 32'hCAFE0001, 0,0,0,1,0,1, 0,0, 0,
            0, 0, 32'hCAFE0001, 9, 1);
    add_vec(32'h10, 0, 13, 32'h1000, 32'h2000, 1,0,1,1,1,1, 0,0,
            32'hA5A5A5A5, 1, 0, 32'hA5A5A5A5, 13, 1);
    add_vec(32'h20, 0, 2, 32'h44, 32'h3333, 0,0,0,1,1,1, 0,0, 0,
            0, 0, 32'h44, 2, 1);
    add_vec(32'h99, 0, 12, 0, 0, 0,0,0,1,0,0, 1,0, 0,
            0, 1, 32'h44, 2, 0);
    add_vec(32'h208, 32'h5555, 0, 0, 0, 0,1,0,0,0,0, 0,0, 0,
            1, 0, 32'h208, 0, 0);
    add_vec(32'h3C, 0, 4, 0, 0, 0,0,0,1,0,0, 0,0, 0,
            0, 0, 32'h3C, 4, 1);

    do_reset();
    chk("rst_wb_regwr", {31'b0, wb_regwr}, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_cnt", {16'b0, scnt}, 0);
    chk("rst_mis", {31'b0, mis}, 0);

    for (int i = 0; i < vq.size(); i++) begin
      vec_t v;
      v = vq[i];
      set_in(v.alu, v.wd, v.rd, v.pcs, v.mul, v.memrd, v.memwr,
             v.m2r, v.regwr, v.jump, v.mulp, v.sext, v.busy, v.rdata);
      if (v.e_regwr) push(v.e_data, v.e_rd);
      bus_chk($sformatf("vec%0d", i), v.e_req, v.e_stall);
      if (v.memrd | v.memwr)
        chk($sformatf("vec%0d_addr", i), {2'b0, dc.dc_addr_o},
            v.alu >> 2);
      tick();
      chk($sformatf("vec%0d_regwr", i), {31'b0, wb_regwr},
          {31'b0, v.e_regwr});
      chk($sformatf("vec%0d_data", i), wb_data, v.e_data);
      chk($sformatf("vec%0d_rd", i), {27'b0, wb_rd}, {27'b0, v.e_rd});
    end
    chk("vec_cnt", {16'b0, scnt}, 1);

    // Load miss, three busy cycles.
    do_reset();
    nst = 0;
    set_in(32'h300, 0, 6, 0, 0, 1,0,1,1,0,0, 0,1, 32'h0BADF00D);
    for (int c = 0; c < 3; c++) begin
      bus_chk("miss", 1, 1);
      chk("miss_addr", {2'b0, dc.dc_addr_o}, 32'hC0);
      tick();
      chk("miss_regwr", {31'b0, wb_regwr}, 0);
    end
    dc.dc_busy_i = 0;
    dc.dc_rdata_i = 32'h600DD00D;
    push(32'h600DD00D, 6);
    bus_chk("miss_done", 1, 0);
    tick();
    chk("miss_wb_regwr", {31'b0, wb_regwr}, 1);
    nop();
    tick();
    chk("miss_once", {31'b0, wb_regwr}, 0);
    chk("miss_nst", nst, 3);
    chk("miss_cnt", {16'b0, scnt}, 3);

    // Miss completes while an external freeze is active.
    do_reset();
    set_in(32'h400, 0, 7, 0, 0, 1,0,1,1,0,0, 0,1, 32'h0);
    bus_chk("hold_c1", 1, 1);
    tick();
    set_in(32'h400, 0, 7, 0, 0, 1,0,1,1,0,0, 1,0, 32'h1234ABCD);
    bus_chk("hold_c2", 1, 1);
    tick();
    chk("hold_regwr2", {31'b0, wb_regwr}, 0);
    for (int c = 0; c < 2; c++) begin
      dc.dc_rdata_i = 32'hFFFF0000 + c;
      bus_chk("hold_frz", 0, 1);
      tick();
      chk("hold_frz_regwr", {31'b0, wb_regwr}, 0);
    end
    sext = 0;
    dc.dc_rdata_i = 32'h0000BEEF;
    push(32'h1234ABCD, 7);
    bus_chk("hold_rel", 0, 0);
    tick();
    chk("hold_wb_regwr", {31'b0, wb_regwr}, 1);
    chk("hold_wb_data", wb_data, 32'h1234ABCD);
    nop();
    tick();
    chk("hold_cnt", {16'b0, scnt}, 4);

    // Store with two busy cycles, then jal and mul.
    do_reset();
    set_in(32'h204, 32'h12345678, 0, 0, 0, 0,1,0,0,0,0, 0,1, 0);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) dc.dc_busy_i = 0;
      bus_chk("st", 1, c < 2);
      chk("st_wen", {31'b0, dc.dc_wen_o}, 1);
      chk("st_wdata", dc.dc_wdata_o, 32'h12345678);
      chk("st_addr", {2'b0, dc.dc_addr_o}, 32'h81);
      tick();
      chk("st_regwr", {31'b0, wb_regwr}, 0);
    end
    set_in(32'h0, 0, 1, 32'h88, 0, 0,0,0,1,1,0, 0,0, 0);
    push(32'h88, 1);
    bus_chk("jal", 0, 0);
    tick();
    chk("jal_data", wb_data, 32'h88);
    set_in(32'h4, 0, 11, 0, 32'h00C0FFEE, 0,0,0,1,0,1, 0,0, 0);
    push(32'h00C0FFEE, 11);
    tick();
    chk("mul_data", wb_data, 32'h00C0FFEE);
    chk("st_cnt", {16'b0, scnt}, 2);

    // Misaligned load is sticky.
    do_reset();
    set_in(32'h102, 0, 8, 0, 0, 1,0,1,1,0,0, 0,0, 32'h77);
    push(32'h77, 8);
    bus_chk("mis", 1, 0);
    chk("mis_addr", {2'b0, dc.dc_addr_o}, 32'h40);
    chk("mis_before", {31'b0, mis}, 0);
    tick();
    chk("mis_set", {31'b0, mis}, 1);
    set_in(32'h104, 0, 8, 0, 0, 1,0,1,0,0,0, 0,0, 32'h1);
    tick();
    nop();
    tick();
    chk("mis_stick", {31'b0, mis}, 1);

    // Reset while waiting on the cache.
    set_in(32'h600, 0, 10, 0, 0, 1,0,1,1,0,0, 0,1, 32'h0);
    bus_chk("rw_c1", 1, 1);
    tick();
    rst_n = 0;
    bus_chk("rw_c2", 1, 1);
    tick();
    rst_n = 1;
    nop();
    dc.dc_busy_i = 1;
    chk("rw_regwr", {31'b0, wb_regwr}, 0);
    chk("rw_data", wb_data, 0);
    chk("rw_rd", {27'b0, wb_rd}, 0);
    chk("rw_mis", {31'b0, mis}, 0);
    chk("rw_cnt", {16'b0, scnt}, 0);
    bus_chk("rw_idle", 0, 0);
    tick();
    tick();
    chk("sb_empty", sbq.size(), 0);

    // Counter saturation under a long external freeze.
    do_reset();
    sext = 1;
    repeat (65534) @(posedge clk);
    #1;
    chk("cnt_fffe", {16'b0, scnt}, 32'hFFFE);
    tick();
    chk("cnt_ffff", {16'b0, scnt}, 32'hFFFF);
    repeat (3) tick();
    chk("cnt_sat", {16'b0, scnt}, 32'hFFFF);
    nop();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
